// File: rtl/proc_host_if.sv
// Command and capture-readout handshake bundle between a host controller and proc_host.
// master drives commands and pops; slave is proc_host.
interface proc_host_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_xor;
  logic       cmd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport master (
    output cmd_valid, cmd_code, cmd_xor, rd_ready,
    input  cmd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_xor, rd_ready,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/proc_host.sv
// proc_host: pulses one processor control strobe, then captures CAPTURE_BYTES of proc_out into a FWFT FIFO; 1+PULSE+SETTLE+CAPTURE cycles accept-to-idle.
// Backpressure: cmd_ready only in IDLE; a full FIFO drops bytes (sticky overflow). PROC_HOST_CHECKSUM_EN adds a checksum output.
module proc_host #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int CAPTURE_BYTES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  proc_host_if.slave  bus,
  output logic [7:0]  proc_ctrl,
  input  logic [7:0]  proc_out,
  output logic        busy,
  output logic        overflow,
  output logic [4:0]  fifo_level
`ifdef PROC_HOST_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int         AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] PULSE_LAST   = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] CAPTURE_LAST = 4'(CAPTURE_BYTES - 1);
  localparam logic [4:0] DEPTH_LVL    = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CAPTURE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] code_q, code_nxt;
  logic       xor_q, xor_nxt;
  logic       push;
  logic       accept;

  function automatic logic [7:0] strobe_of(input logic [2:0] code);
    case (code)
      3'd0:    strobe_of = 8'h01;
      3'd1:    strobe_of = 8'h02;
      3'd2:    strobe_of = 8'h08;
      3'd3:    strobe_of = 8'h10;
      3'd4:    strobe_of = 8'h20;
      default: strobe_of = 8'h00;
    endcase
  endfunction

  assign accept        = bus.cmd_valid && (state == IDLE);
  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      code_q <= 3'd0;
      xor_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      code_q <= code_nxt;
      xor_q  <= xor_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
    xor_nxt   = xor_q;
    proc_ctrl = 8'h00;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // Reserved codes are consumed here without leaving IDLE.
        if (accept && (bus.cmd_code <= 3'd4)) begin
          code_nxt  = bus.cmd_code;
          xor_nxt   = bus.cmd_xor;
          cnt_nxt   = 4'd0;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        proc_ctrl = strobe_of(code_q) | (xor_q ? 8'h04 : 8'h00);
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = CAPTURE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      CAPTURE: begin
        push = 1'b1;
        if (cnt == CAPTURE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;

  assign empty = (fifo_level == 5'd0);
  assign full  = (fifo_level == DEPTH_LVL);
  assign pop   = !empty && bus.rd_ready;
  // When full, a same-cycle pop frees the head slot, which is where wr_ptr points.
  assign wr_en = push && (!full || pop);

  assign bus.rd_valid = !empty;
  assign bus.rd_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= proc_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PROC_HOST_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      checksum <= 8'h00;
    end else if (wr_en) begin
      checksum <= checksum ^ proc_out;
    end
  end
`endif

endmodule

// File: tb/tb_proc_host.sv
// Directed bench for proc_host at default parameters; a byte queue holds the expected FIFO contents.
module tb_proc_host;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] proc_ctrl;
  logic [7:0] proc_out;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_level;
`ifdef PROC_HOST_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  proc_host_if bus();

  proc_host dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .proc_ctrl  (proc_ctrl),
    .proc_out   (proc_out),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
`ifdef PROC_HOST_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  logic       ovf_m = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic capture_cycle(input logic [7:0] b, input logic pop);
    logic [7:0] h;
    proc_out     = b;
    bus.rd_ready = pop;
    if (pop && sb.size() > 0) begin
      chk("cap_rd_valid", 8'(bus.rd_valid), 8'd1);
      h = sb.pop_front();
      chk("cap_rd_data", bus.rd_data, h);
    end
    if (sb.size() < DEPTH) sb.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic run_cmd(input logic [2:0] code, input logic xr, input logic [7:0] exp_ctrl,
                         input logic [31:0] bytes, input logic pop, input logic hold);
    bus.cmd_code  = code;
    bus.cmd_xor   = xr;
    bus.cmd_valid = 1'b1;
    chk("idle_ready", 8'(bus.cmd_ready), 8'd1);
    chk("idle_ctrl", proc_ctrl, 8'h00);
    step();
    if (!hold) bus.cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("pulse_ctrl", proc_ctrl, exp_ctrl);
      chk("pulse_busy", 8'(busy), 8'd1);
      chk("pulse_ready", 8'(bus.cmd_ready), 8'd0);
      step();
    end
    chk("settle_ctrl", proc_ctrl, 8'h00);
    chk("settle_busy", 8'(busy), 8'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("cap_ctrl", proc_ctrl, 8'h00);
      chk("cap_busy", 8'(busy), 8'd1);
      capture_cycle(bytes[31-8*i -: 8], pop);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    proc_out      = 8'hEE;
    chk("done_busy", 8'(busy), 8'd0);
    chk("done_ready", 8'(bus.cmd_ready), 8'd1);
    chk("done_ctrl", proc_ctrl, 8'h00);
    chk("done_level", 8'(fifo_level), 8'(sb.size()));
    chk("done_ovf", 8'(overflow), 8'(ovf_m));
  endtask

  task automatic drain();
    logic [7:0] h;
    bus.rd_ready = 1'b1;
    while (sb.size() > 0) begin
      chk("drain_valid", 8'(bus.rd_valid), 8'd1);
      h = sb.pop_front();
      chk("drain_data", bus.rd_data, h);
      step();
    end
    bus.rd_ready = 1'b0;
    chk("drain_empty", 8'(bus.rd_valid), 8'd0);
    chk("drain_level", 8'(fifo_level), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 3'd0;
    bus.cmd_xor   = 1'b0;
    bus.rd_ready  = 1'b0;
    proc_out      = 8'h00;
    rst           = 1'b1;
    step();
    step();
    chk("rst_ready", 8'(bus.cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ctrl", proc_ctrl, 8'h00);
    chk("rst_rd_valid", 8'(bus.rd_valid), 8'd0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_level", 8'(fifo_level), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    rst = 1'b0;

    // Pop while empty is ignored.
    bus.rd_ready = 1'b1;
    step();
    chk("empty_pop_level", 8'(fifo_level), 8'd0);
    chk("empty_pop_valid", 8'(bus.rd_valid), 8'd0);
    bus.rd_ready = 1'b0;

    run_cmd(3'd0, 1'b0, 8'h01, 32'h4849210A, 1'b0, 1'b0);
    drain();
    run_cmd(3'd4, 1'b1, 8'h24, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    chk("no_after_ctrl", proc_ctrl, 8'h00);
    drain();
    run_cmd(3'd1, 1'b0, 8'h02, 32'h01020304, 1'b0, 1'b0);
    drain();

    // cmd_valid held through the whole command must not queue a second one.
    run_cmd(3'd2, 1'b1, 8'h0C, 32'hA5A55A5A, 1'b0, 1'b1);
    step();
    chk("hold_busy", 8'(busy), 8'd0);
    chk("hold_level", 8'(fifo_level), 8'd4);
    drain();
    run_cmd(3'd3, 1'b0, 8'h10, $urandom, 1'b0, 1'b0);
    drain();

    // Reserved code: consumed, no strobe, no capture.
    bus.cmd_code  = 3'd6;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("rsv_ready", 8'(bus.cmd_ready), 8'd1);
    chk("rsv_busy", 8'(busy), 8'd0);
    chk("rsv_ctrl", proc_ctrl, 8'h00);
    step();
    chk("rsv_ctrl2", proc_ctrl, 8'h00);
    chk("rsv_level", 8'(fifo_level), 8'd0);
    chk("rsv_valid", 8'(bus.rd_valid), 8'd0);

    // Fill to exactly full, push+pop while full, then overflow.
    run_cmd(3'd0, 1'b0, 8'h01, 32'h10111213, 1'b0, 1'b0);
    run_cmd(3'd0, 1'b0, 8'h01, 32'h20212223, 1'b0, 1'b0);
    run_cmd(3'd0, 1'b0, 8'h01, 32'h30313233, 1'b1, 1'b0);
    run_cmd(3'd0, 1'b0, 8'h01, 32'h40414243, 1'b0, 1'b0);
    chk("ovf_level", 8'(fifo_level), 8'd8);
    chk("ovf_set", 8'(overflow), 8'd1);
    drain();
    chk("ovf_sticky", 8'(overflow), 8'd1);

    // Reset during the PULSE of READOUT with data in the FIFO.
    run_cmd(3'd0, 1'b0, 8'h01, 32'h50515253, 1'b0, 1'b0);
    bus.cmd_code  = 3'd1;
    bus.cmd_xor   = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("mid_pulse_ctrl", proc_ctrl, 8'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    chk("mid_rst_ctrl", proc_ctrl, 8'h00);
    chk("mid_rst_ready", 8'(bus.cmd_ready), 8'd1);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_level", 8'(fifo_level), 8'd0);
    chk("mid_rst_valid", 8'(bus.rd_valid), 8'd0);
    chk("mid_rst_data", bus.rd_data, 8'h00);
    chk("mid_rst_ovf", 8'(overflow), 8'd0);
    step();
    chk("abandon_ctrl", proc_ctrl, 8'h00);
    chk("abandon_busy", 8'(busy), 8'd0);

    run_cmd(3'd0, 1'b1, 8'h05, 32'h6162636F, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
